// File: rtl/sprite_frame_loader.sv
// Copies one WIDTH x HEIGHT frame from a multi-frame sync ROM into the sprite RAM,
// optionally mirrored horizontally, advancing only while vblank is high.
module sprite_frame_loader #(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 8,
  parameter int FRAMES    = 2,
  parameter int COLR_BITS = 4,
  parameter int ADDRW     = $clog2(WIDTH*HEIGHT),
  parameter int SRC_ADDRW = $clog2(FRAMES*WIDTH*HEIGHT),
  parameter int FRAMEW    = $clog2(FRAMES)+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [FRAMEW-1:0]    cmd_frame,
  input  logic                 cmd_flip,
  input  logic                 vblank,
  output logic [SRC_ADDRW-1:0] src_addr,
  input  logic [COLR_BITS-1:0] src_data,
  output logic                 wr_en,
  output logic [ADDRW-1:0]     wr_addr,
  output logic [COLR_BITS-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int NPIX = WIDTH*HEIGHT;
  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [FRAMEW-1:0]    frame_q, frame_d;
  logic                 flip_q, flip_d;
  logic [SRC_ADDRW-1:0] src_addr_q, src_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDRW-1:0]     wr_addr_q, wr_addr_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 issue;
  logic [SRC_ADDRW-1:0] rd_addr;
  logic [CW-1:0]        col_x;
  logic [ADDRW-1:0]     dst_addr;

  assign issue    = (state_q == COPY) && vblank;
  assign rd_addr  = SRC_ADDRW'(frame_q) * SRC_ADDRW'(NPIX)
                  + SRC_ADDRW'(row_q) * SRC_ADDRW'(WIDTH) + SRC_ADDRW'(col_q);
  assign col_x    = flip_q ? (CW'(WIDTH-1) - col_q) : col_q;
  assign dst_addr = ADDRW'(row_q) * ADDRW'(WIDTH) + ADDRW'(col_x);

  // The address is live only in the cycle a read is issued; otherwise it holds.
  assign src_addr  = issue ? rd_addr : src_addr_q;
  // ROM output is registered, so data lines up with the write one cycle later.
  assign wr_data   = src_data;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    frame_d     = frame_q;
    flip_d      = flip_q;
    src_addr_d  = src_addr;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        frame_d     = cmd_frame;
        flip_d      = cmd_flip;
        row_d       = '0;
        col_d       = '0;
        cmd_ready_d = 1'b0;
        busy_d      = 1'b1;
        if (cmd_frame >= FRAMEW'(FRAMES)) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = COPY;
        end
      end
      COPY: if (vblank) begin
        wr_en_d   = 1'b1;
        wr_addr_d = dst_addr;
        if (col_q == CW'(WIDTH-1)) begin
          col_d = '0;
          if (row_q == RW'(HEIGHT-1)) state_d = DRAIN;
          else                        row_d   = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      flip_q      <= 1'b0;
      src_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      flip_q      <= flip_d;
      src_addr_q  <= src_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_sprite_frame_loader.sv
// Bench for sprite_frame_loader: table vectors, reset-mid-copy sequence and random
// commands, all checked against a cycle-level model derived from the vblank pattern.
module tb_sprite_frame_loader;
  localparam int W = 4, H = 2, F = 2, CB = 4, AW = 3, SAW = 4, FW = 2, N = W*H;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [FW-1:0]  cmd_frame = '0;
  logic           cmd_flip = 1'b0;
  logic           vblank = 1'b0;
  logic [SAW-1:0] src_addr;
  logic [CB-1:0]  src_data;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [CB-1:0]  wr_data;
  logic           busy, done, err;

  sprite_frame_loader #(.WIDTH(W), .HEIGHT(H), .FRAMES(F), .COLR_BITS(CB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_frame(cmd_frame), .cmd_flip(cmd_flip), .vblank(vblank),
    .src_addr(src_addr), .src_data(src_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Sync ROM: word i holds i[3:0]; with a 4-bit address that is the address itself.
  logic [CB-1:0] rom_q = '0;
  always @(posedge clk) rom_q <= src_addr;
  assign src_data = rom_q;

  int n_chk = 0, n_pass = 0;
  int last_src = 0;
  bit vb [0:63];
  int ram [0:N-1];
  int wcnt [0:N-1];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One command: the model lists, per cycle after acceptance, which read/write should occur.
  task automatic run_cmd(input int frame, input bit flip, input int stray_at,
                         input bit exp_err, input int exp_done);
    bit rd [0:63]; bit we [0:63];
    int ra [0:63]; int wa [0:63]; int wd [0:63];
    int done_c, last, k, dut_done;
    bit bad;
    bad = (frame >= F);
    for (int c = 0; c < 64; c++) begin rd[c] = 0; we[c] = 0; ra[c] = 0; wa[c] = 0; wd[c] = 0; end
    for (int i = 0; i < N; i++) begin ram[i] = -1; wcnt[i] = 0; end
    last = 0; k = 0; dut_done = -1;
    if (!bad) begin
      for (int c = 1; c < 60 && k < N; c++) begin
        if (vb[c]) begin
          rd[c] = 1; ra[c] = frame*N + k;
          we[c+1] = 1;
          wa[c+1] = (k/W)*W + (flip ? W-1-(k%W) : k%W);
          wd[c+1] = (frame*N + k) % 16;
          k++; last = c;
        end
      end
      done_c = last + 2;
    end else begin
      done_c = 1;
    end
    if (exp_done < 0) exp_done = done_c;

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_frame = FW'(frame); cmd_flip = flip; vblank = vb[0];
    @(negedge clk);
    chk("accept_ready", int'(cmd_ready), 1);
    chk("accept_busy", int'(busy), 0);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      cmd_valid = (c == stray_at && c <= done_c);
      cmd_frame = (c == stray_at) ? FW'($urandom_range(0, 3)) : FW'(frame);
      vblank = vb[c];
      @(negedge clk);
      chk("src_addr", int'(src_addr), rd[c] ? ra[c] : last_src);
      if (rd[c]) last_src = ra[c];
      chk("wr_en", int'(wr_en), int'(we[c]));
      if (we[c]) begin
        chk("wr_addr", int'(wr_addr), wa[c]);
        chk("wr_data", int'(wr_data), wd[c]);
      end
      if (wr_en) begin ram[wr_addr] = int'(wr_data); wcnt[wr_addr]++; end
      chk("done", int'(done), int'(c == done_c));
      if (done && dut_done < 0) dut_done = c;
      if (c == done_c) chk("err", int'(err), int'(exp_err));
      chk("cmd_ready", int'(cmd_ready), int'(c == done_c + 1));
      chk("busy", int'(busy), int'(c <= done_c));
    end
    cmd_valid = 1'b0;
    chk("done_cycle", dut_done, exp_done);
    if (!bad) begin
      for (int i = 0; i < N; i++) begin
        int col;
        col = flip ? W-1-(i%W) : i%W;
        chk("ram_once", wcnt[i], 1);
        chk("ram_value", ram[i], (frame*N + (i/W)*W + col) % 16);
      end
    end
  endtask

  typedef struct {
    int frame; bit flip; int pause_at; int pause_len; int stray_at;
    bit exp_err; int exp_done;
  } vec_t;

  vec_t tbl [0:5];

  initial begin
    int dcnt;
    tbl[0] = '{1, 1'b0, 0, 0, -1, 1'b0, 10};  // basic copy
    tbl[1] = '{0, 1'b1, 0, 0, -1, 1'b0, 10};  // mirrored
    tbl[2] = '{0, 1'b0, 4, 4, -1, 1'b0, 14};  // vblank pause after 3rd read
    tbl[3] = '{2, 1'b0, 0, 0, -1, 1'b1, 1};   // bad frame
    tbl[4] = '{1, 1'b0, 0, 0, 4,  1'b0, 10};  // command while busy is ignored
    tbl[5] = '{3, 1'b1, 0, 0, -1, 1'b1, 1};   // bad frame, top index

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_src_addr", int'(src_addr), 0);

    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < 64; c++)
        vb[c] = !(tbl[t].pause_len > 0 && c >= tbl[t].pause_at && c < tbl[t].pause_at + tbl[t].pause_len);
      run_cmd(tbl[t].frame, tbl[t].flip, tbl[t].stray_at, tbl[t].exp_err, tbl[t].exp_done);
    end

    // Reset in the middle of a copy.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_frame = 2'd1; cmd_flip = 1'b0; vblank = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_wr_en", int'(wr_en), int'(c >= 2));
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    last_src = 0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || wr_en) dcnt++;
    end
    chk("midrst_quiet", dcnt, 0);
    for (int c = 0; c < 64; c++) vb[c] = 1'b1;
    run_cmd(0, 1'b1, -1, 1'b0, 10);

    // Random commands with random vblank gaps.
    for (int r = 0; r < 20; r++) begin
      int fr, st;
      bit fl;
      fr = $urandom_range(0, 3);
      fl = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1;
      for (int c = 0; c < 64; c++) vb[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      run_cmd(fr, fl, st, fr >= F, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
